// File: rtl/core_dmem_responder_if.sv
// Core data-memory bus between the LSU (master) and a memory target (slave).
interface core_dmem_responder_if;
  logic        req;
  logic [63:0] addr;
  logic        wen;
  logic [7:0]  strb;
  logic [63:0] wdata;
  logic        gnt;
  logic        err;
  logic [63:0] rdata;

  modport master (
    output req, addr, wen, strb, wdata,
    input  gnt, err, rdata
  );

  modport slave (
    input  req, addr, wen, strb, wdata,
    output gnt, err, rdata
  );
endinterface

// File: rtl/core_dmem_responder.sv
// Byte-strobed 64-bit scratchpad RAM target on the core dmem bus, with wait states
// and range errors. Define CORE_DMEM_RESPONDER_ROM_PROTECT_EN to write-protect the low ROM_WORDS words.
module core_dmem_responder #(
  parameter logic [63:0] BASE        = 64'h0000_0000_0001_0000,
  parameter int          DEPTH       = 1024,
  parameter int          WAIT_CYCLES = 1,
  parameter int          ROM_WORDS   = 16
) (
  input  logic                        g_clk,
  input  logic                        g_resetn,
  core_dmem_responder_if.slave        dmem
);

  localparam int          IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [63:0] SPAN      = 64'(DEPTH) * 64'd8;
  localparam logic [63:0] ROM_SPAN  = 64'(ROM_WORDS) * 64'd8;
  localparam logic [3:0]  WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

`ifdef CORE_DMEM_RESPONDER_ROM_PROTECT_EN
  localparam bit ROM_PROTECT = 1'b1;
`else
  localparam bit ROM_PROTECT = 1'b0;
`endif

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]       state;
  logic [3:0]       cnt;
  logic             err_q;
  logic [63:0]      rdata_q;
  logic [63:0]      mem [DEPTH];

  logic [63:0]      offset;
  logic [IDX_W-1:0] idx;
  logic             legal;
  logic             rom_hit;
  logic             access_ok;
  logic             gnt;
  logic             unused_offset;

  // Subtraction wraps for addresses below BASE, so a single unsigned compare covers both ends.
  assign offset        = dmem.addr - BASE;
  assign idx           = offset[IDX_W+2:3];
  assign legal         = (offset < SPAN) && (dmem.addr[2:0] == 3'b000);
  assign rom_hit       = offset < ROM_SPAN;
  assign access_ok     = legal && !(ROM_PROTECT && dmem.wen && rom_hit);
  assign unused_offset = ^{offset[63:IDX_W+3], offset[2:0]};

  // Grant is suppressed while reset is held so a transaction caught by reset is dropped.
  assign gnt = g_resetn && dmem.req &&
               (((state == S_IDLE) && (WAIT_CYCLES == 0)) ||
                ((state == S_WAIT) && (cnt == 4'd0)));

  assign dmem.gnt   = gnt;
  assign dmem.err   = err_q;
  assign dmem.rdata = rdata_q;

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      state   <= S_IDLE;
      cnt     <= 4'd0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      err_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (dmem.req) begin
            if (WAIT_CYCLES == 0) begin
              state <= S_RESP;
            end else begin
              cnt   <= WAIT_INIT;
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (!dmem.req) begin
            state <= S_IDLE;
          end else if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state <= S_RESP;
          end
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
      // Response reflects the pre-write word, captured at the same edge as the write.
      if (gnt) begin
        err_q   <= !access_ok;
        rdata_q <= access_ok ? mem[idx] : '0;
      end
    end
  end

  always_ff @(posedge g_clk) begin
    if (gnt && access_ok && dmem.wen) begin
      for (int b = 0; b < 8; b++) begin
        if (dmem.strb[b]) begin
          mem[idx][8*b +: 8] <= dmem.wdata[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_core_dmem_responder.sv
// Directed self-checking bench for core_dmem_responder (WAIT_CYCLES=1 and WAIT_CYCLES=0 instances).
module tb_core_dmem_responder;

  logic        g_clk = 1'b0;
  logic        g_resetn = 1'b0;
  logic        sel = 1'b0;
  logic        req = 1'b0;
  logic [63:0] addr = '0;
  logic        wen = 1'b0;
  logic [7:0]  strb = '0;
  logic [63:0] wdata = '0;

  int n_checks = 0;
  int n_errors = 0;

  core_dmem_responder_if bus1 ();
  core_dmem_responder_if bus0 ();

  // sel routes requests to the zero-wait instance; the other instance sees req=0.
  assign bus1.req   = req & ~sel;
  assign bus1.addr  = addr;
  assign bus1.wen   = wen;
  assign bus1.strb  = strb;
  assign bus1.wdata = wdata;
  assign bus0.req   = req & sel;
  assign bus0.addr  = addr;
  assign bus0.wen   = wen;
  assign bus0.strb  = strb;
  assign bus0.wdata = wdata;

  logic        gnt_obs;
  logic        err_obs;
  logic [63:0] rdata_obs;
  assign gnt_obs   = sel ? bus0.gnt   : bus1.gnt;
  assign err_obs   = sel ? bus0.err   : bus1.err;
  assign rdata_obs = sel ? bus0.rdata : bus1.rdata;

  core_dmem_responder #(
    .BASE(64'h1_0000), .DEPTH(1024), .WAIT_CYCLES(1), .ROM_WORDS(16)
  ) u_dut (
    .g_clk(g_clk), .g_resetn(g_resetn), .dmem(bus1)
  );

  core_dmem_responder #(
    .BASE(64'h1_0000), .DEPTH(1024), .WAIT_CYCLES(0), .ROM_WORDS(16)
  ) u_dut0 (
    .g_clk(g_clk), .g_resetn(g_resetn), .dmem(bus0)
  );

  always #5 g_clk = ~g_clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full transaction: waits for gnt, checks wait count, the response cycle and the cycle after.
  task automatic applyStimulus(input string tag, input logic [63:0] a, input logic w,
                               input logic [7:0] s, input logic [63:0] d, input int exp_wait,
                               input logic exp_err, input logic chk_rd, input logic [63:0] exp_rd);
    int waits;
    bit got;
    @(negedge g_clk);
    req = 1'b1; addr = a; wen = w; strb = s; wdata = d;
    waits = 0;
    got = 1'b0;
    while (!got && waits < 20) begin
      #1;
      if (gnt_obs) got = 1'b1;
      else begin
        waits++;
        @(negedge g_clk);
      end
    end
    checkOutput({tag, "_gnt_seen"}, 64'(got), 64'd1);
    if (got) begin
      checkOutput({tag, "_wait"}, 64'(waits), 64'(exp_wait));
      @(negedge g_clk);
      req = 1'b0;
      #1;
      checkOutput({tag, "_resp_gnt"}, 64'(gnt_obs), 64'd0);
      checkOutput({tag, "_err"}, 64'(err_obs), 64'(exp_err));
      if (chk_rd) checkOutput({tag, "_rdata"}, rdata_obs, exp_rd);
      @(negedge g_clk);
      #1;
      checkOutput({tag, "_err_after"}, 64'(err_obs), 64'd0);
    end else begin
      req = 1'b0;
    end
  endtask

  initial begin
    $display("[TB] start");
    repeat (3) @(posedge g_clk);
    @(negedge g_clk);
    #1;
    checkOutput("reset_gnt", 64'(bus1.gnt), 64'd0);
    checkOutput("reset_err", 64'(bus1.err), 64'd0);
    checkOutput("reset_rdata", bus1.rdata, 64'd0);
    g_resetn = 1'b1;

    applyStimulus("wr_full", 64'h10008, 1'b1, 8'hFF, 64'h1122334455667788, 1, 1'b0, 1'b0, 64'd0);
    applyStimulus("rd_full", 64'h10008, 1'b0, 8'h00, 64'd0, 1, 1'b0, 1'b1, 64'h1122334455667788);
    applyStimulus("wr_byte", 64'h10008, 1'b1, 8'h04, 64'h0000000000AA0000, 1, 1'b0, 1'b1, 64'h1122334455667788);
    applyStimulus("rd_byte", 64'h10008, 1'b0, 8'hFF, 64'd0, 1, 1'b0, 1'b1, 64'h1122334455AA7788);
    applyStimulus("wr_nostrb", 64'h10008, 1'b1, 8'h00, 64'hFFFFFFFFFFFFFFFF, 1, 1'b0, 1'b1, 64'h1122334455AA7788);
    applyStimulus("rd_nostrb", 64'h10008, 1'b0, 8'h00, 64'd0, 1, 1'b0, 1'b1, 64'h1122334455AA7788);

    applyStimulus("rd_oor_high", 64'h12000, 1'b0, 8'h00, 64'd0, 1, 1'b1, 1'b1, 64'd0);
    applyStimulus("wr_oor_low", 64'h0FFF8, 1'b1, 8'hFF, 64'hCAFECAFECAFECAFE, 1, 1'b1, 1'b1, 64'd0);
    applyStimulus("rd_misalign", 64'h1000C, 1'b0, 8'h00, 64'd0, 1, 1'b1, 1'b1, 64'd0);
    applyStimulus("rd_after_oor", 64'h10008, 1'b0, 8'h00, 64'd0, 1, 1'b0, 1'b1, 64'h1122334455AA7788);

    applyStimulus("wr_last", 64'h11FF8, 1'b1, 8'hFF, 64'h5555AAAA5555AAAA, 1, 1'b0, 1'b0, 64'd0);
    applyStimulus("rd_last", 64'h11FF8, 1'b0, 8'h00, 64'd0, 1, 1'b0, 1'b1, 64'h5555AAAA5555AAAA);

    // Abort: request withdrawn while in WAIT must produce no grant and no write.
    applyStimulus("wr_abort_pre", 64'h10010, 1'b1, 8'hFF, 64'h0123456789ABCDEF, 1, 1'b0, 1'b0, 64'd0);
    @(negedge g_clk);
    req = 1'b1; addr = 64'h10010; wen = 1'b1; strb = 8'hFF; wdata = 64'hFFFFFFFFFFFFFFFF;
    #1;
    checkOutput("abort_gnt_idle", 64'(gnt_obs), 64'd0);
    @(negedge g_clk);
    req = 1'b0;
    #1;
    checkOutput("abort_gnt_wait", 64'(gnt_obs), 64'd0);
    @(negedge g_clk);
    #1;
    checkOutput("abort_gnt_after", 64'(gnt_obs), 64'd0);
    checkOutput("abort_err_after", 64'(err_obs), 64'd0);
    applyStimulus("rd_abort", 64'h10010, 1'b0, 8'h00, 64'd0, 1, 1'b0, 1'b1, 64'h0123456789ABCDEF);

    // Reset asserted in WAIT with the request still held.
    @(negedge g_clk);
    req = 1'b1; addr = 64'h10010; wen = 1'b1; strb = 8'hFF; wdata = 64'd0;
    @(negedge g_clk);
    g_resetn = 1'b0;
    #1;
    checkOutput("rstwait_gnt", 64'(gnt_obs), 64'd0);
    @(negedge g_clk);
    req = 1'b0;
    #1;
    checkOutput("rstwait_gnt_after", 64'(gnt_obs), 64'd0);
    checkOutput("rstwait_err", 64'(err_obs), 64'd0);
    checkOutput("rstwait_rdata", rdata_obs, 64'd0);
    g_resetn = 1'b1;
    applyStimulus("rd_rstwait", 64'h10010, 1'b0, 8'h00, 64'd0, 1, 1'b0, 1'b1, 64'h0123456789ABCDEF);

`ifdef CORE_DMEM_RESPONDER_ROM_PROTECT_EN
    applyStimulus("wr_rom", 64'h10000, 1'b1, 8'hFF, 64'hDEAD, 1, 1'b1, 1'b1, 64'd0);
    applyStimulus("rd_rom", 64'h10000, 1'b0, 8'h00, 64'd0, 1, 1'b0, 1'b0, 64'd0);
    checkOutput("rom_not_written", 64'(rdata_obs == 64'hDEAD), 64'd0);
`else
    applyStimulus("wr_rom", 64'h10000, 1'b1, 8'hFF, 64'hDEAD, 1, 1'b0, 1'b0, 64'd0);
    applyStimulus("rd_rom", 64'h10000, 1'b0, 8'h00, 64'd0, 1, 1'b0, 1'b1, 64'hDEAD);
`endif
    applyStimulus("wr_above_rom", 64'h10080, 1'b1, 8'hFF, 64'hDEAD, 1, 1'b0, 1'b0, 64'd0);
    applyStimulus("rd_above_rom", 64'h10080, 1'b0, 8'h00, 64'd0, 1, 1'b0, 1'b1, 64'hDEAD);

    // Zero-wait instance: single transactions, then a held request grants every other cycle.
    sel = 1'b1;
    applyStimulus("w0_wr", 64'h10020, 1'b1, 8'hFF, 64'hA5A5A5A5_5A5A5A5A, 0, 1'b0, 1'b0, 64'd0);
    applyStimulus("w0_rd", 64'h10020, 1'b0, 8'h00, 64'd0, 0, 1'b0, 1'b1, 64'hA5A5A5A5_5A5A5A5A);
    applyStimulus("w0_oor", 64'h12000, 1'b0, 8'h00, 64'd0, 0, 1'b1, 1'b1, 64'd0);
    @(negedge g_clk);
    req = 1'b1; addr = 64'h10020; wen = 1'b0; strb = 8'h00;
    for (int k = 0; k < 6; k++) begin
      #1;
      checkOutput($sformatf("w0_b2b_gnt%0d", k), 64'(gnt_obs), 64'((k % 2) == 0));
      @(negedge g_clk);
    end
    req = 1'b0;
    #1;
    checkOutput("w0_b2b_rdata", rdata_obs, 64'hA5A5A5A5_5A5A5A5A);
    sel = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not reach the end");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/core_dmem_responder.md
Name: core_dmem_responder

Overview:
- Target side of the core data-memory bus (dmem_req/gnt/err/rdata): a single-ported, byte-strobed 64-bit scratchpad RAM with configurable wait states and address-range error reporting.
- Sits opposite the execute-stage LSU in core-level testbenches and small SoC builds.
- Accepts one transaction at a time and returns read data and error status in the cycle after grant.

Parameters:
- BASE, 64'h0000_0000_0001_0000, byte base address of the RAM window; must be 8-byte aligned.
- DEPTH, 1024, number of 64-bit words.
- WAIT_CYCLES, 1, stall cycles inserted between req first seen and gnt (0..15).
- ROM_WORDS, 16, words at the bottom of the window that are write-protected (used only with the optional feature).

Ports:
- g_clk  input  1  global clock
- g_resetn  input  1  synchronous active-low reset
- dmem_req  input  1  request valid
- dmem_addr  input  64  byte address, expected 8-byte aligned
- dmem_wen  input  1  1 = write, 0 = read
- dmem_strb  input  8  byte write strobes, bit i -> wdata[8i+7:8i]
- dmem_wdata  input  64  write data
- dmem_gnt  output  1  request accepted this cycle
- dmem_err  output  1  response error, valid in response cycle
- dmem_rdata  output  64  response read data, valid in response cycle

Behaviour:
- Interface: clock g_clk; reset g_resetn, synchronous, active-low.
- Reset values: dmem_gnt=0, dmem_err=0, dmem_rdata=0, FSM=IDLE, wait counter=0. RAM contents are not reset.
- Requester protocol: requester holds req, addr, wen, strb and wdata stable until it samples gnt=1.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req=1 and WAIT_CYCLES=0: gnt=1 combinationally this cycle; next state RESP.
  - req=1 and WAIT_CYCLES>0: counter loads WAIT_CYCLES-1; next state WAIT; gnt=0.
- WAIT:
  - req=0: abort to IDLE. No access and no response.
  - req=1 and counter!=0: counter decrements; gnt=0.
  - req=1 and counter==0: gnt=1; next state RESP.
- RESP:
  - Lasts exactly one cycle. dmem_err and dmem_rdata carry the result of the granted access. gnt=0 regardless of req. Next state IDLE.
  - Minimum spacing between grants is 2 cycles at WAIT_CYCLES=0.
- Access is performed at the clock edge ending the gnt cycle:
  - Address is legal iff BASE <= addr < BASE+DEPTH*8 and addr[2:0]==0.
  - Word index = (addr-BASE)>>3, using 64-bit unsigned arithmetic, so a wrapping subtraction below BASE is out of range.
  - Legal write: bytes with strb[i]=1 updated; others unchanged.
  - strb=0 write: granted, no change, err=0.
  - Read ignores strb.
  - Legal read: dmem_rdata = word; err=0.
  - Legal write: err=0; dmem_rdata = pre-write word value (read-before-write).
  - Illegal access: err=1, dmem_rdata=0, no RAM change.
- Outside RESP: dmem_err=0. dmem_rdata holds its last value (0 after reset).
- Reset mid-operation: a write is committed only if its gnt cycle completed before reset was sampled. Reset during WAIT or the gnt cycle drops the transaction.
- Request in RESP: ignored until IDLE, then handled as a fresh request (full wait count).

Optional Feature:
- Macro: CORE_DMEM_RESPONDER_ROM_PROTECT_EN.
- Defined: a write to word index < ROM_WORDS is granted normally, returns err=1 and rdata=0, and leaves the RAM unchanged. Reads of those words behave normally.
- Undefined: ROM_WORDS is ignored and all in-range words are writable.

Test Plan (BASE=0x10000, DEPTH=1024, WAIT_CYCLES=1, macro undefined unless stated):
- Write and read back: write 0x1122334455667788, strb=0xFF, to 0x10008 -> gnt one cycle after req, err=0. Read 0x10008 -> gnt after 1 wait, then next cycle rdata=0x1122334455667788, err=0.
- Byte strobe: after the write above, write wdata=0x0000000000AA0000, strb=0x04, to 0x10008. Read back -> 0x1122334455AA7788.
- Out of range: read 0x12000 -> gnt, then err=1 for exactly one cycle, rdata=0. A write to 0x0FFF8 -> err=1 and RAM unchanged.
- Abort: write to 0x10010 with req dropped during WAIT -> no gnt, no err. A later read of 0x10010 returns the prior value.
- Reset mid-WAIT: assert g_resetn=0 during WAIT -> gnt=0, err=0, rdata=0, FSM IDLE, target word unchanged. WAIT_CYCLES=0 back-to-back requests -> gnt on cycles n and n+2 only.
- ROM protect (macro defined, ROM_WORDS=16): write 0xDEAD to 0x10000 -> err=1, readback unchanged. Write to 0x10080 -> err=0, readback 0xDEAD. With the macro undefined, the write to 0x10000 succeeds.
